matrix_result_writer: RTL
=========================

Name: matrix_result_writer

Overview:
Downstream stage of the matrix-multiply core. It starts after the core asserts done and reads the 64-entry x 32-bit result buffer through the core's synchronous read port. It packs the words 16 per 512-bit cache line and issues 4 write-line requests to consecutive host addresses. It then writes a completion-flag line and waits for all write acks before pulsing done to the AFU control FSM.

Parameters:
N_WORDS, 64, result words in buffer; must be a multiple of WORDS_PER_CL
WORD_W, 32, result word width
WORDS_PER_CL, 16, words per cache line (512 / WORD_W)
CL_ADDR_W, 42, cache-line address width
RD_ADDR_W, 6, result buffer read address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin a writeback; sampled only in IDLE
base_addr  in  CL_ADDR_W  destination line address; captured on an accepted start
z_rd_addr  out  RD_ADDR_W  result buffer read address
z_dout  in  WORD_W  result buffer data; valid 1 cycle after z_rd_addr
wr_valid  out  1  write-line request valid; one-cycle pulse per line
wr_addr  out  CL_ADDR_W  request line address
wr_data  out  512  request line data
wr_almfull  in  1  channel almost full; no new request while high
wr_ack  in  1  one write response per cycle, max
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when all acks have been received
lines_issued  out  8  lines issued in the current or last run, flag line included

Behaviour:
- Reset values: all outputs 0. State goes to IDLE. Counters and data register are cleared.
- FSM states: IDLE, FETCH, ISSUE, FLAG, WAIT_ACK, FIN.
- IDLE -> FETCH on start: capture base_addr, clear lines_issued, clear ack count, set line index li=0. A start in any other state is ignored.
- FETCH:
  - Drive z_rd_addr = li*16 + k for k = 0..15 on consecutive cycles.
  - Latch z_dout one cycle later into data bits [32k+31:32k].
  - Duration is 17 cycles. z_rd_addr stays at the last address during the trailing cycle. Then go to ISSUE.
- ISSUE:
  - If wr_almfull is 0: assert wr_valid for exactly 1 cycle with wr_addr = base + li and wr_data = the packed line. Increment lines_issued.
  - If li < N_WORDS/WORDS_PER_CL - 1: li++ and go to FETCH. Otherwise go to FLAG.
  - While wr_almfull is high: hold in ISSUE with wr_valid = 0 and data held. There is no request dropping.
- FLAG:
  - Same almfull rule as ISSUE. Issue one line at base + N_WORDS/WORDS_PER_CL (e.g. base + 4).
  - Flag data: [63:0] = 64'h1; [95:64] = checksum (see feature); [127:96] = 32-bit data-line count (4); remainder 0.
  - Then go to WAIT_ACK.
- Acks:
  - Counted in every non-IDLE state. Acks may arrive before all requests are issued.
  - An ack in IDLE is ignored.
  - The ack count saturates at the expected total.
- WAIT_ACK -> FIN when ack count == lines_issued (5).
- FIN: done = 1 for one cycle, then IDLE. busy drops in the same cycle that done rises.
- wr_valid, wr_addr and wr_data are registered outputs. wr_data is held stable while wr_valid = 0.
- Address arithmetic is modulo 2^CL_ADDR_W; wrap is permitted and not flagged.
- Reset mid-operation:
  - Return to IDLE immediately.
  - Deassert wr_valid the next cycle.
  - Discard in-flight acks; later stray acks arrive in IDLE and are ignored.

Optional Feature:
MATRIX_WR_CHECKSUM_EN
- Defined: a 32-bit modulo-2^32 running sum of every latched z_dout word goes into flag bits [95:64]. The sum clears on an accepted start.
- Undefined: bits [95:64] = 0 and no accumulator logic is generated.

Test Plan:
- Nominal run: z[i] = i, base_addr = 0x1000, almfull = 0, acks 3 cycles after each request.
  - Lines go to 0x1000..0x1003; line 0 word k = k and line 3 word 0 = 48.
  - Flag goes to 0x1004 with [63:0] = 1 and [127:96] = 4.
  - done pulses once; lines_issued = 5.
- Checksum: same data with MATRIX_WR_CHECKSUM_EN defined -> flag [95:64] = 0x7E0. Undefined -> 0.
- Backpressure: wr_almfull high for 10 cycles on entering ISSUE for line 2 -> no wr_valid in those cycles. The line then issues once with unchanged data, and the total is still 5 requests.
- Ack timing: acks for lines 0-3 arrive during the flag FETCH/ISSUE, and the flag ack arrives 20 cycles later -> done fires only after the 5th ack.
- Start while busy: second start with base_addr = 0x2000 in the middle of the run -> ignored; all writes target 0x1000..0x1004.
- Reset during FETCH of line 1, then a new start with base_addr = 0x3000 and a stray ack injected in IDLE:
  - The stray ack is ignored.
  - The new run writes 0x3000..0x3004 and completes with exactly 5 acks.

Source files
------------

// File: rtl/matrix_result_writer.sv
// ---------------------------------------------------------------------------
// matrix_result_writer
//
// Writeback stage of the matrix-multiply core.  After a start pulse it reads
// the result buffer through its synchronous read port and packs WORDS_PER_CL
// words into each cache line.  It issues one write-line request per line to
// consecutive host line addresses, then writes a completion-flag line.  Once
// every write has been acknowledged it pulses done.
//
// Optional feature macro: MATRIX_WR_CHECKSUM_EN
//   defined   -> flag line bits [95:64] carry a mod-2^32 sum of all result words
//   undefined -> flag line bits [95:64] are zero; no accumulator is built
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   start         one-cycle pulse, accepted only while idle
//   base_addr     destination line address, captured on an accepted start
//   z_rd_addr     result buffer read address (registered)
//   z_dout        result buffer data, valid one cycle after z_rd_addr
//   wr_valid      one-cycle write-line request strobe
//   wr_addr       request line address
//   wr_data       request line data, held while wr_valid is low
//   wr_almfull    write channel almost full; no new request while high
//   wr_ack        write response, at most one per cycle
//   busy          high from the cycle after an accepted start until done
//   done          one-cycle completion pulse
//   lines_issued  lines issued in this/last run, flag line included
// ---------------------------------------------------------------------------
module matrix_result_writer #(
  parameter int N_WORDS      = 64,
  parameter int WORD_W       = 32,
  parameter int WORDS_PER_CL = 16,
  parameter int CL_ADDR_W    = 42,
  parameter int RD_ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  output logic [RD_ADDR_W-1:0] z_rd_addr,
  input  logic [WORD_W-1:0]    z_dout,
  output logic                 wr_valid,
  output logic [CL_ADDR_W-1:0] wr_addr,
  output logic [511:0]         wr_data,
  input  logic                 wr_almfull,
  input  logic                 wr_ack,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           lines_issued
);

  localparam int N_LINES = N_WORDS / WORDS_PER_CL;
  localparam int WSEL_W  = $clog2(WORDS_PER_CL);
  localparam int K_W     = WSEL_W + 1;   // fetch counter runs 0..WORDS_PER_CL

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, FLAG, WAIT_ACK, FIN} state_t;

  state_t                              state_reg;
  logic [K_W-1:0]                      fetch_cnt_reg;
  logic [7:0]                          li_reg;
  logic [7:0]                          ack_cnt_reg;
  logic [CL_ADDR_W-1:0]                base_reg;
  logic [WORDS_PER_CL-1:0][WORD_W-1:0] line_reg;
  logic [31:0]                         csum;
  logic [511:0]                        flag_line;
  logic                                latch_en;
  logic [WSEL_W-1:0]                   wsel;

  // Read data for the address driven in fetch cycle k arrives in cycle k+1,
  // so cycles 1..WORDS_PER_CL of FETCH each capture word (k-1).  The low
  // bits minus one give that index (WORDS_PER_CL wraps to the last word).
  assign latch_en = (state_reg == FETCH) && (fetch_cnt_reg != '0);
  assign wsel     = fetch_cnt_reg[WSEL_W-1:0] - WSEL_W'(1);

`ifdef MATRIX_WR_CHECKSUM_EN
  logic [31:0] csum_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      csum_reg <= '0;
    end else if (latch_en) begin
      csum_reg <= csum_reg + 32'(z_dout);
    end
  end

  assign csum = csum_reg;
`else
  assign csum = '0;
`endif

  always_comb begin
    flag_line         = '0;
    flag_line[63:0]   = 64'h1;
    flag_line[95:64]  = csum;
    flag_line[127:96] = 32'(N_LINES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      fetch_cnt_reg <= '0;
      li_reg        <= '0;
      ack_cnt_reg   <= '0;
      base_reg      <= '0;
      line_reg      <= '0;
      z_rd_addr     <= '0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_issued  <= '0;
    end else begin
      wr_valid <= 1'b0;
      done     <= 1'b0;

      // Acks may overtake issue; count them anywhere but IDLE and saturate
      // at the number of lines a run can ever issue.
      if (state_reg != IDLE && wr_ack && ack_cnt_reg != 8'(N_LINES + 1)) begin
        ack_cnt_reg <= ack_cnt_reg + 8'd1;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg      <= base_addr;
            lines_issued  <= '0;
            ack_cnt_reg   <= '0;
            li_reg        <= '0;
            fetch_cnt_reg <= '0;
            z_rd_addr     <= '0;
            busy          <= 1'b1;
            state_reg     <= FETCH;
          end
        end

        FETCH: begin
          if (latch_en) begin
            line_reg[wsel] <= z_dout;
          end
          // Address stops at the last word and stays there for the trailing
          // capture cycle.
          if (fetch_cnt_reg < K_W'(WORDS_PER_CL - 1)) begin
            z_rd_addr <= z_rd_addr + RD_ADDR_W'(1);
          end
          if (fetch_cnt_reg == K_W'(WORDS_PER_CL)) begin
            state_reg <= ISSUE;
          end else begin
            fetch_cnt_reg <= fetch_cnt_reg + K_W'(1);
          end
        end

        ISSUE: begin
          if (!wr_almfull) begin
            wr_valid     <= 1'b1;
            wr_addr      <= base_reg + CL_ADDR_W'(li_reg);
            wr_data      <= line_reg;
            lines_issued <= lines_issued + 8'd1;
            if (li_reg < 8'(N_LINES - 1)) begin
              li_reg        <= li_reg + 8'd1;
              fetch_cnt_reg <= '0;
              z_rd_addr     <= z_rd_addr + RD_ADDR_W'(1);  // first word of next line
              state_reg     <= FETCH;
            end else begin
              state_reg <= FLAG;
            end
          end
        end

        FLAG: begin
          if (!wr_almfull) begin
            wr_valid     <= 1'b1;
            wr_addr      <= base_reg + CL_ADDR_W'(N_LINES);
            wr_data      <= flag_line;
            lines_issued <= lines_issued + 8'd1;
            state_reg    <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (ack_cnt_reg == lines_issued) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= FIN;
          end
        end

        FIN: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
